// File: rtl/fifo_wr_gen_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_gen_if : FIFO write-port bundle (enable, data, full flag).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_wr_gen_if #(
  parameter int DATASIZE = 8
) ();
  logic                w_en;
  logic [DATASIZE-1:0] wdata;
  logic                wfull_flag;

  // master = traffic generator, slave = FIFO write side
  modport master (output w_en, output wdata, input  wfull_flag);
  modport slave  (input  w_en, input  wdata, output wfull_flag);
endinterface

`default_nettype wire

// File: rtl/fifo_wr_gen.sv
// ---------------------------------------------------------------------------
// fifo_wr_gen : write-side burst traffic generator for the async FIFO (wclk).
// Define FIFO_WR_GEN_LFSR_EN for an 8-bit LFSR data pattern.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_wr_gen #(
  parameter int DATASIZE = 8,
  parameter int BURST_W  = 8,
  parameter int GAP_W    = 4
) (
  input  wire logic               i_wclk,
  input  wire logic               i_wrst_n,
  input  wire logic               i_start,
  input  wire logic [BURST_W-1:0] i_burst_len,
  input  wire logic [GAP_W-1:0]   i_gap,
  input  wire logic [DATASIZE-1:0] i_seed,
  fifo_wr_gen_if.master           wr_if,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BURST_W-1:0]      o_wr_cnt,
  output logic [15:0]             o_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BURST_W-1:0]  len_q, len_d;
  logic [BURST_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [BURST_W-1:0]  wr_cnt_inc;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DATASIZE-1:0] wdata_q, wdata_d;
  logic [DATASIZE-1:0] next_data;
  logic [DATASIZE-1:0] seed_eff;
  logic [15:0]         stall_q, stall_d;
  logic                beat;

`ifdef FIFO_WR_GEN_LFSR_EN
  generate
    if (DATASIZE != 8) begin : g_lfsr_width_chk
      $error("fifo_wr_gen: LFSR pattern requires DATASIZE == 8");
    end
  endgenerate

  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1
  assign next_data = {wdata_q[DATASIZE-2:0], wdata_q[7] ^ wdata_q[5] ^ wdata_q[4] ^ wdata_q[3]};
  assign seed_eff  = (i_seed == '0) ? DATASIZE'(1) : i_seed;
`else
  assign next_data = wdata_q + DATASIZE'(1);
  assign seed_eff  = i_seed;
`endif

  // Zero-latency backpressure: never write in a cycle where the FIFO is full
  assign beat       = (state_q == WRITE) & ~wr_if.wfull_flag;
  assign wr_cnt_inc = wr_cnt_q + BURST_W'(1);

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wdata_q   <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wdata_q   <= wdata_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wdata_d   = wdata_q;
    stall_d   = stall_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d    = i_burst_len;
          gap_d    = i_gap;
          wdata_d  = seed_eff;
          wr_cnt_d = '0;
          stall_d  = '0;
          state_d  = (i_burst_len == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wr_if.wfull_flag) begin
          if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          wdata_d  = next_data;
          wr_cnt_d = wr_cnt_inc;
          if (wr_cnt_inc == len_q) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_if.w_en  = beat;
  assign wr_if.wdata = wdata_q;
  assign o_busy      = (state_q == WRITE) | (state_q == GAP);
  assign o_done      = (state_q == DONE);
  assign o_wr_cnt    = wr_cnt_q;
  assign o_stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_gen.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_gen : directed bench for fifo_wr_gen with a behavioural 16-deep FIFO.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_gen;
  localparam int DATASIZE = 8;
  localparam int BURST_W  = 8;
  localparam int GAP_W    = 4;
  localparam int DEPTH    = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_s = 1'b0;
  logic [BURST_W-1:0]  len_s = '0;
  logic [GAP_W-1:0]    gap_s = '0;
  logic [DATASIZE-1:0] seed_s = '0;
  logic                busy;
  logic                done;
  logic [BURST_W-1:0]  wr_cnt;
  logic [15:0]         stall_cnt;

  int checks = 0;
  int errors = 0;

  fifo_wr_gen_if #(.DATASIZE(DATASIZE)) wif ();

  fifo_wr_gen #(
    .DATASIZE (DATASIZE),
    .BURST_W  (BURST_W),
    .GAP_W    (GAP_W)
  ) dut (
    .i_wclk      (clk),
    .i_wrst_n    (rst_n),
    .i_start     (start_s),
    .i_burst_len (len_s),
    .i_gap       (gap_s),
    .i_seed      (seed_s),
    .wr_if       (wif),
    .o_busy      (busy),
    .o_done      (done),
    .o_wr_cnt    (wr_cnt),
    .o_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: full flag in the write domain, popped data logged
  logic [DATASIZE-1:0] mem [DEPTH];
  int                  wptr = 0;
  int                  rptr = 0;
  int                  fcount = 0;
  logic                rd_en = 1'b1;
  logic                fifo_clr = 1'b0;
  logic                tb_push;
  logic                tb_pop;
  logic [DATASIZE-1:0] rd_log [$];

  assign wif.wfull_flag = (fcount == DEPTH);
  assign tb_push = wif.w_en && (fcount != DEPTH);
  assign tb_pop  = rd_en && (fcount != 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wptr   <= 0;
      rptr   <= 0;
      fcount <= 0;
    end else begin
      if (tb_push) begin
        mem[wptr] <= wif.wdata;
        wptr      <= (wptr + 1) % DEPTH;
      end
      if (tb_pop) begin
        rd_log.push_back(mem[rptr]);
        rptr <= (rptr + 1) % DEPTH;
      end
      fcount <= fcount + int'(tb_push) - int'(tb_pop);
    end
  end

  int                  beat_cyc [$];
  logic [DATASIZE-1:0] beat_dat [$];
  int                  done_cyc [$];
  int                  viol;

  function automatic string fmt_i(input int q[$]);
    string s = "";
    for (int i = 0; i < q.size() && i < 24; i++) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic string fmt_d(input logic [DATASIZE-1:0] q[$]);
    string s = "";
    for (int i = 0; i < q.size() && i < 24; i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    rd_log.delete();
  endtask

  // Start accepted at the next edge (edge N); returns in cycle N+1
  task automatic do_start(input logic [BURST_W-1:0] len, input logic [GAP_W-1:0] gap,
                          input logic [DATASIZE-1:0] seed);
    start_s = 1'b1;
    len_s   = len;
    gap_s   = gap;
    seed_s  = seed;
    @(posedge clk); #1;
    start_s = 1'b0;
  endtask

  // Samples cycles 1..n after the start edge; optional reader enable and re-start
  task automatic observe(input int n, input int rd_on, input int restart_at,
                         input logic [BURST_W-1:0] restart_len);
    beat_cyc.delete();
    beat_dat.delete();
    done_cyc.delete();
    viol = 0;
    for (int c = 1; c <= n; c++) begin
      if (wif.w_en) begin
        beat_cyc.push_back(c);
        beat_dat.push_back(wif.wdata);
        if (wif.wfull_flag) viol++;
      end
      if (done) done_cyc.push_back(c);
      if (c == rd_on) rd_en = 1'b1;
      if (c == restart_at) begin
        start_s = 1'b1;
        len_s   = restart_len;
      end else begin
        start_s = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, wif.w_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/w_en=%b want 000", {busy, done, wif.w_en});
    end
    checks++;
    if (wr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
    checks++;
    if (wif.wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_wdata: got %h want 00", wif.wdata);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic ok;
    clear_fifo();
    rd_en = 1'b1;
    do_start(8'd16, 4'd0, 8'h00);
    observe(20, 0, 0, 8'd0);
    ok = (beat_cyc.size() == 16);
    for (int i = 0; i < beat_cyc.size(); i++)
      if (beat_cyc[i] != i + 1 || beat_dat[i] !== 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_beats: cycles %s data %s want cycles 1..16 data 00..0f",
               fmt_i(beat_cyc), fmt_d(beat_dat));
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 17) begin
      errors++;
      $display("FAIL basic_done: done cycles %s want 17", fmt_i(done_cyc));
    end
    checks++;
    if (wr_cnt !== 8'd16) begin
      errors++;
      $display("FAIL basic_wr_cnt: got %0d want 16", wr_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL basic_stall: got %0d want 0", stall_cnt);
    end
    ok = (rd_log.size() == 16);
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_readback: got %s want 00..0f", fmt_d(rd_log));
    end
  endtask

  task automatic test_gap();
    logic ok;
    int                  exp_c [4];
    logic [DATASIZE-1:0] exp_d [4];
    exp_c = '{1, 4, 7, 10};
    exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_start(8'd4, 4'd2, 8'hFE);
    observe(14, 0, 0, 8'd0);
    ok = (beat_cyc.size() == 4);
    for (int i = 0; i < 4 && ok; i++)
      if (beat_cyc[i] != exp_c[i] || beat_dat[i] !== exp_d[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_beats: cycles %s data %s want cycles 1 4 7 10 data fe ff 00 01",
               fmt_i(beat_cyc), fmt_d(beat_dat));
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      errors++;
      $display("FAIL gap_done: done cycles %s want 11", fmt_i(done_cyc));
    end
    checks++;
    if (wr_cnt !== 8'd4) begin
      errors++;
      $display("FAIL gap_wr_cnt: got %0d want 4", wr_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    clear_fifo();
    rd_en = 1'b0;
    do_start(8'd20, 4'd0, 8'h40);
    // FIFO fills after cycle 16; reader enabled at the end of cycle 26
    observe(34, 26, 0, 8'd0);
    ok = (beat_cyc.size() == 20);
    for (int i = 0; i < beat_cyc.size(); i++)
      if (beat_cyc[i] != ((i < 16) ? i + 1 : i + 11) || beat_dat[i] !== 8'(8'h40 + i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_beats: cycles %s data %s want cycles 1..16,27..30 data 40..53",
               fmt_i(beat_cyc), fmt_d(beat_dat));
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bp_write_while_full: got %0d writes want 0", viol);
    end
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL bp_stall: got %0d want 10", stall_cnt);
    end
    checks++;
    if (wr_cnt !== 8'd20) begin
      errors++;
      $display("FAIL bp_wr_cnt: got %0d want 20", wr_cnt);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 31) begin
      errors++;
      $display("FAIL bp_done: done cycles %s want 31", fmt_i(done_cyc));
    end
  endtask

  task automatic test_zero_len();
    do_start(8'd0, 4'd0, 8'h55);
    observe(6, 0, 1, 8'd5);
    checks++;
    if (beat_cyc.size() != 0) begin
      errors++;
      $display("FAIL zero_beats: got %0d beats want 0", beat_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
      errors++;
      $display("FAIL zero_done: done cycles %s want 1", fmt_i(done_cyc));
    end
    checks++;
    if (wr_cnt !== 8'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_counts: wr_cnt %0d stall %0d want 0 0", wr_cnt, stall_cnt);
    end
    do_start(8'd3, 4'd0, 8'h10);
    observe(8, 0, 2, 8'd7);
    checks++;
    if (beat_cyc.size() != 3 || beat_dat[0] !== 8'h10 || beat_dat[2] !== 8'h12) begin
      errors++;
      $display("FAIL busy_restart_beats: cycles %s data %s want cycles 1 2 3 data 10 11 12",
               fmt_i(beat_cyc), fmt_d(beat_dat));
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 4) begin
      errors++;
      $display("FAIL busy_restart_done: done cycles %s want 4", fmt_i(done_cyc));
    end
    checks++;
    if (wr_cnt !== 8'd3) begin
      errors++;
      $display("FAIL busy_restart_wr_cnt: got %0d want 3", wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    do_start(8'd10, 4'd0, 8'h00);
    observe(5, 0, 0, 8'd0);
    checks++;
    if (wr_cnt !== 8'd5) begin
      errors++;
      $display("FAIL mid_pre_cnt: got %0d want 5", wr_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, wif.w_en} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_ctrl: busy/done/w_en=%b want 000", {busy, done, wif.w_en});
    end
    checks++;
    if (wr_cnt !== 8'd0 || stall_cnt !== 16'd0 || wif.wdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_regs: wr_cnt %0d stall %0d wdata %h want 0 0 00",
               wr_cnt, stall_cnt, wif.wdata);
    end
    observe(4, 0, 0, 8'd0);
    checks++;
    if (done_cyc.size() != 0 || beat_cyc.size() != 0) begin
      errors++;
      $display("FAIL mid_rst_quiet: %0d done pulses %0d beats want 0 0",
               done_cyc.size(), beat_cyc.size());
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(8'd8, 4'd0, 8'h20);
    observe(12, 0, 0, 8'd0);
    ok = (beat_cyc.size() == 8);
    for (int i = 0; i < beat_cyc.size(); i++)
      if (beat_cyc[i] != i + 1 || beat_dat[i] !== 8'(8'h20 + i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_rerun_beats: cycles %s data %s want cycles 1..8 data 20..27",
               fmt_i(beat_cyc), fmt_d(beat_dat));
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 9 || wr_cnt !== 8'd8) begin
      errors++;
      $display("FAIL mid_rerun_done: done cycles %s wr_cnt %0d want 9 and 8",
               fmt_i(done_cyc), wr_cnt);
    end
  endtask

  task automatic test_pattern();
    logic ok;
    logic [DATASIZE-1:0] exp_d [3];
`ifdef FIFO_WR_GEN_LFSR_EN
    exp_d = '{8'h01, 8'h02, 8'h04};
`else
    exp_d = '{8'h00, 8'h01, 8'h02};
`endif
    clear_fifo();
    rd_en = 1'b1;
    do_start(8'd3, 4'd0, 8'h00);
    observe(8, 0, 0, 8'd0);
    ok = (beat_dat.size() == 3);
    for (int i = 0; i < 3 && ok; i++) if (beat_dat[i] !== exp_d[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pattern_wdata: got %s want %02h %02h %02h",
               fmt_d(beat_dat), exp_d[0], exp_d[1], exp_d[2]);
    end
    ok = (rd_log.size() == 3);
    for (int i = 0; i < 3 && ok; i++) if (rd_log[i] !== exp_d[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pattern_readback: got %s want %02h %02h %02h",
               fmt_d(rd_log), exp_d[0], exp_d[1], exp_d[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 ns");
    $fatal(1);
  end

endmodule

`default_nettype wire
